// File: rtl/mem_mmio_pit_pkg.sv
// Memory map constants and shared helpers for the data RAM / timer bank block.
package mem_map_pkg;

    localparam int unsigned RAM_BASE   = 32'h0;
    localparam int unsigned TMR_STRIDE = 16;

    // Register word offsets inside one timer channel (byte offset >> 2)
    typedef enum logic [1:0] {
        TMR_LOAD   = 2'd0,
        TMR_COUNT  = 2'd1,
        TMR_CTRL   = 2'd2,
        TMR_STATUS = 2'd3
    } tmr_reg_e;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_PERIODIC  = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int STATUS_EXPIRED = 0;

    // Byte-lane merge: lanes set in 'lanes' take new_word, others keep old_word
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = lanes[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_mmio_pit_if.sv
// CPU-side bus of the memory/MMIO block: two read ports, one byte-lane write port,
// fault pulse and timer interrupt lines.
interface mem_mmio_pit_if #(
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned N_TIMERS = 4
);
    logic                clk_en;
    logic [ADDR_W-1:0]   raddr0;
    logic [31:0]         rdata0;
    logic [ADDR_W-1:0]   raddr1;
    logic [31:0]         rdata1;
    logic [3:0]          wen;
    logic [ADDR_W-1:0]   waddr;
    logic [31:0]         wdata;
    logic                fault;
    logic [N_TIMERS-1:0] irq;

    modport master (
        output clk_en, raddr0, raddr1, wen, waddr, wdata,
        input  rdata0, rdata1, fault, irq
    );

    modport slave (
        input  clk_en, raddr0, raddr1, wen, waddr, wdata,
        output rdata0, rdata1, fault, irq
    );
endinterface

// File: rtl/mem_mmio_pit_pit_channel.sv
// One programmable interval timer: LOAD/COUNT/CTRL/EXPIRED registers and a registered irq.
// Runs on the shared prescaler tick; register writes arrive already qualified by clk_en.
module pit_channel
    import mem_map_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [3:0]  wen,
    input  logic [1:0]  woff,
    input  logic [31:0] wdata,
    output logic [31:0] load,
    output logic [31:0] count,
    output logic [2:0]  ctrl,
    output logic        expired,
    output logic        irq
);
    logic load_we;
    logic ctrl_we;
    logic clr_we;
    logic expire_now;

    // Write decode and terminal-count detection
    always_comb begin
        load_we    = (wen != 4'd0) && (tmr_reg_e'(woff) == TMR_LOAD);
        ctrl_we    = wen[0] && (tmr_reg_e'(woff) == TMR_CTRL);
        clr_we     = wen[0] && (tmr_reg_e'(woff) == TMR_STATUS) && wdata[STATUS_EXPIRED];
        expire_now = tick && ctrl[CTRL_EN] && (count <= 32'd1);
    end

    // Timer state: tick effects first, then register writes override (CTRL write wins,
    // an expiring tick beats a same-cycle clear of EXPIRED)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load    <= '0;
            count   <= '0;
            ctrl    <= '0;
            expired <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (load_we) begin
                load <= merge_lanes(load, wdata, wen);
            end
            if (tick && ctrl[CTRL_EN]) begin
                if (count > 32'd1) begin
                    count <= count - 32'd1;
                end else if (ctrl[CTRL_PERIODIC]) begin
                    count <= load;
                end else begin
                    count         <= '0;
                    ctrl[CTRL_EN] <= 1'b0;
                end
            end
            if (ctrl_we) begin
                ctrl <= wdata[2:0];
                if (wdata[CTRL_EN] && !ctrl[CTRL_EN]) begin
                    count <= load;
                end
            end
            if (expire_now) begin
                expired <= 1'b1;
            end else if (clr_we) begin
                expired <= 1'b0;
            end
            irq <= expired && ctrl[CTRL_IRQ_EN];
        end
    end
endmodule

// File: rtl/mem_mmio_pit.sv
// Data RAM (2 read / 1 write, write-first forwarding) plus a bank of interval timers.
// Reads take two clk_en cycles: the issuing cycle latches the looked-up word, the next
// enabled cycle moves it to rdata. Unmapped accesses read 0 and raise a one-clk fault.
module mem_mmio_pit
    import mem_map_pkg::*;
#(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned RAM_WORDS  = 32768,
    parameter int unsigned N_TIMERS   = 4,
    parameter int unsigned TIMER_BASE = 32'h20010,
    parameter int unsigned PRESCALE   = 1
)(
    input  logic           clk,
    input  logic           rst_n,
    mem_mmio_pit_if.slave  bus
);
    localparam int unsigned IDX_W     = $clog2(RAM_WORDS);
    localparam int unsigned PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned RAM_LIMIT = RAM_BASE + 4 * RAM_WORDS;
    localparam int unsigned TMR_LIMIT = TIMER_BASE + TMR_STRIDE * N_TIMERS;

    logic [31:0]         mem [RAM_WORDS];
    logic [31:0]         t_load  [N_TIMERS];
    logic [31:0]         t_count [N_TIMERS];
    logic [2:0]          t_ctrl  [N_TIMERS];
    logic [3:0]          t_wen   [N_TIMERS];
    logic [N_TIMERS-1:0] t_exp;
    logic [N_TIMERS-1:0] irq_vec;
    logic [31:0]         rd0_next, rd1_next, s1_data0, s1_data1;
    logic                map0, map1, mapw, ram_we, tmr_we, tick;
    logic [PS_W-1:0]     ps_cnt;

    function automatic logic is_ram(input logic [ADDR_W-1:0] a);
        return 32'(a) < RAM_LIMIT;
    endfunction

    function automatic logic is_tmr(input logic [ADDR_W-1:0] a);
        return (32'(a) >= TIMER_BASE) && (32'(a) < TMR_LIMIT);
    endfunction

    function automatic logic [31:0] tmr_read(input logic [ADDR_W-1:0] a);
        logic [31:0] off;
        logic [31:0] r;
        off = 32'(a) - TIMER_BASE;
        r   = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            if ((off >> 4) == 32'(i)) begin
                case (tmr_reg_e'(off[3:2]))
                    TMR_LOAD:   r = t_load[i];
                    TMR_COUNT:  r = t_count[i];
                    TMR_CTRL:   r = {29'd0, t_ctrl[i]};
                    TMR_STATUS: r = {31'd0, t_exp[i]};
                    default:    r = '0;
                endcase
            end
        end
        return r;
    endfunction

    // Same-cycle write to the word being read is merged lane by lane (write-first)
    function automatic logic [31:0] port_read(input logic [ADDR_W-1:0] a,
                                              input logic [ADDR_W-1:0] wa,
                                              input logic [31:0]       wd,
                                              input logic [3:0]        we);
        logic [31:0] r;
        r = '0;
        if (is_ram(a)) begin
            r = mem[a[IDX_W+1:2]];
            if ((we != 4'd0) && is_ram(wa) && (wa[ADDR_W-1:2] == a[ADDR_W-1:2])) begin
                r = merge_lanes(r, wd, we);
            end
        end else if (is_tmr(a)) begin
            r = tmr_read(a);
        end
        return r;
    endfunction

    // Address decode, read lookup and per-channel write enables
    always_comb begin
        map0     = is_ram(bus.raddr0) || is_tmr(bus.raddr0);
        map1     = is_ram(bus.raddr1) || is_tmr(bus.raddr1);
        mapw     = is_ram(bus.waddr)  || is_tmr(bus.waddr);
        rd0_next = port_read(bus.raddr0, bus.waddr, bus.wdata, bus.wen);
        rd1_next = port_read(bus.raddr1, bus.waddr, bus.wdata, bus.wen);
        ram_we   = bus.clk_en && (bus.wen != 4'd0) && is_ram(bus.waddr);
        tmr_we   = bus.clk_en && (bus.wen != 4'd0) && is_tmr(bus.waddr);
        for (int i = 0; i < N_TIMERS; i++) begin
            t_wen[i] = (tmr_we && (((32'(bus.waddr) - TIMER_BASE) >> 4) == 32'(i)))
                       ? bus.wen : 4'd0;
        end
    end

    // RAM byte-lane write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.wen[k]) begin
                    mem[bus.waddr[IDX_W+1:2]][8*k +: 8] <= bus.wdata[8*k +: 8];
                end
            end
        end
    end

    // Two-stage read pipeline (held when clk_en=0) and the unmapped-access fault pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data0   <= '0;
            s1_data1   <= '0;
            bus.rdata0 <= '0;
            bus.rdata1 <= '0;
            bus.fault  <= 1'b0;
        end else begin
            if (bus.clk_en) begin
                s1_data0   <= rd0_next;
                s1_data1   <= rd1_next;
                bus.rdata0 <= s1_data0;
                bus.rdata1 <= s1_data1;
            end
            bus.fault <= bus.clk_en && (!map0 || !map1 || ((bus.wen != 4'd0) && !mapw));
        end
    end

    // Free-running prescaler shared by all channels; tick on terminal count
    assign tick = (ps_cnt == '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= tick ? PS_W'(PRESCALE - 1) : ps_cnt - 1'b1;
        end
    end

    for (genvar i = 0; i < N_TIMERS; i++) begin : g_tmr
        pit_channel u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .wen     (t_wen[i]),
            .woff    (bus.waddr[3:2]),
            .wdata   (bus.wdata),
            .load    (t_load[i]),
            .count   (t_count[i]),
            .ctrl    (t_ctrl[i]),
            .expired (t_exp[i]),
            .irq     (irq_vec[i])
        );
    end

    assign bus.irq = irq_vec;
endmodule

// File: tb/tb_mem_mmio_pit.sv
// Directed bench for mem_mmio_pit: RAM path, forwarding, timers, fault, async reset.
module tb_mem_mmio_pit;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_mmio_pit_if #(.ADDR_W(18), .N_TIMERS(4)) bus_i ();

    mem_mmio_pit #(
        .ADDR_W(18), .RAM_WORDS(32768), .N_TIMERS(4),
        .TIMER_BASE(32'h20010), .PRESCALE(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [17:0] a, input logic [31:0] d, input logic [3:0] m);
        bus_i.waddr = a;
        bus_i.wdata = d;
        bus_i.wen   = m;
        cyc();
        bus_i.wen   = 4'd0;
    endtask

    task automatic rd(input logic [17:0] a0, input logic [17:0] a1);
        bus_i.raddr0 = a0;
        bus_i.raddr1 = a1;
        cyc();
        cyc();
    endtask

    initial begin
        bus_i.clk_en = 1'b1;
        bus_i.raddr0 = '0;
        bus_i.raddr1 = '0;
        bus_i.waddr  = '0;
        bus_i.wdata  = '0;
        bus_i.wen    = 4'd0;
        #2 rst_n = 1'b0;
        cyc();
        cyc();
        check("rst_rdata0", bus_i.rdata0, 32'h0);
        check("rst_rdata1", bus_i.rdata1, 32'h0);
        check("rst_fault", {31'd0, bus_i.fault}, 32'h0);
        check("rst_irq", {28'd0, bus_i.irq}, 32'h0);
        rst_n = 1'b1;
        cyc();

        // 1: basic write/read and clk_en hold
        wr(18'h00100, 32'hDEADBEEF, 4'hF);
        rd(18'h00100, 18'h00100);
        check("t1_rdata0", bus_i.rdata0, 32'hDEADBEEF);
        check("t1_rdata1", bus_i.rdata1, 32'hDEADBEEF);
        check("t1_nofault", {31'd0, bus_i.fault}, 32'h0);
        bus_i.raddr0 = 18'h00200;
        bus_i.clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t1_hold0", bus_i.rdata0, 32'hDEADBEEF);
            check("t1_hold1", bus_i.rdata1, 32'hDEADBEEF);
        end
        bus_i.clk_en = 1'b1;

        // 2: same-cycle forwarding on lanes 0 and 2
        wr(18'h00040, 32'h11223344, 4'hF);
        bus_i.waddr  = 18'h00040;
        bus_i.wdata  = 32'hAABBCCDD;
        bus_i.wen    = 4'b0101;
        bus_i.raddr0 = 18'h00040;
        bus_i.raddr1 = 18'h00100;
        cyc();
        bus_i.wen    = 4'd0;
        bus_i.raddr1 = 18'h00040;
        cyc();
        check("t2_fwd", bus_i.rdata0, 32'h11BB33DD);
        check("t2_other", bus_i.rdata1, 32'hDEADBEEF);
        cyc();
        check("t2_ram", bus_i.rdata1, 32'h11BB33DD);

        // 3: one-shot timer 0, LOAD=3, CTRL=EN|IRQ_EN
        wr(18'h20010, 32'd3, 4'hF);
        wr(18'h20018, 32'h5, 4'hF);
        cyc();
        cyc();
        cyc();
        check("t3_irq_lat", {28'd0, bus_i.irq}, 32'h0);
        cyc();
        check("t3_irq", {28'd0, bus_i.irq}, 32'h1);
        rd(18'h20018, 18'h2001C);
        check("t3_ctrl", bus_i.rdata0, 32'h4);
        check("t3_status", bus_i.rdata1, 32'h1);
        rd(18'h20014, 18'h20010);
        check("t3_count", bus_i.rdata0, 32'h0);
        check("t3_load", bus_i.rdata1, 32'h3);
        wr(18'h2001C, 32'h1, 4'hF);
        cyc();
        check("t3_irq_clr", {28'd0, bus_i.irq}, 32'h0);
        rd(18'h2001C, 18'h00100);
        check("t3_status_clr", bus_i.rdata0, 32'h0);

        // 4: periodic timer 2, LOAD=2, CTRL=EN|PERIODIC
        wr(18'h20030, 32'd2, 4'hF);
        bus_i.waddr  = 18'h20038;
        bus_i.wdata  = 32'h3;
        bus_i.wen    = 4'hF;
        bus_i.raddr0 = 18'h20034;
        cyc();
        bus_i.wen = 4'd0;
        cyc();
        cyc();
        check("t4_cnt_a", bus_i.rdata0, 32'd2);
        cyc();
        check("t4_cnt_b", bus_i.rdata0, 32'd1);
        cyc();
        check("t4_cnt_c", bus_i.rdata0, 32'd2);
        bus_i.waddr = 18'h2003C;
        bus_i.wdata = 32'h1;
        bus_i.wen   = 4'hF;
        cyc();
        check("t4_cnt_d", bus_i.rdata0, 32'd1);
        bus_i.raddr1 = 18'h2003C;
        cyc();
        bus_i.wen = 4'd0;
        cyc();
        check("t4_w1c_clear", bus_i.rdata1, 32'h0);
        cyc();
        check("t4_set_wins", bus_i.rdata1, 32'h1);
        check("t4_no_irq", {28'd0, bus_i.irq}, 32'h0);
        wr(18'h20038, 32'h0, 4'hF);

        // 5: unmapped read and write
        bus_i.raddr0 = 18'h3FFF0;
        bus_i.raddr1 = 18'h00100;
        cyc();
        check("t5_rd_fault", {31'd0, bus_i.fault}, 32'h1);
        bus_i.raddr0 = 18'h00100;
        cyc();
        check("t5_rd_fault_end", {31'd0, bus_i.fault}, 32'h0);
        check("t5_rd_zero", bus_i.rdata0, 32'h0);
        wr(18'h20008, 32'hFFFFFFFF, 4'hF);
        check("t5_wr_fault", {31'd0, bus_i.fault}, 32'h1);
        cyc();
        check("t5_wr_fault_end", {31'd0, bus_i.fault}, 32'h0);
        rd(18'h20010, 18'h00100);
        check("t5_tmr_kept", bus_i.rdata0, 32'd3);
        check("t5_ram_kept", bus_i.rdata1, 32'hDEADBEEF);

        // 6: async reset mid-count on timer 1 with irq high
        wr(18'h20020, 32'd5, 4'hF);
        wr(18'h20028, 32'h7, 4'hF);
        repeat (6) cyc();
        check("t6_irq_pre", {28'd0, bus_i.irq}, 32'h2);
        repeat (2) cyc();
        #2 rst_n = 1'b0;
        #1;
        check("t6_irq_rst", {28'd0, bus_i.irq}, 32'h0);
        check("t6_rdata_rst", bus_i.rdata0, 32'h0);
        cyc();
        rst_n = 1'b1;
        rd(18'h20024, 18'h20028);
        check("t6_count_rst", bus_i.rdata0, 32'h0);
        check("t6_ctrl_rst", bus_i.rdata1, 32'h0);
        repeat (3) cyc();
        check("t6_count_idle", bus_i.rdata0, 32'h0);
        check("t6_irq_idle", {28'd0, bus_i.irq}, 32'h0);
        wr(18'h20020, 32'd10, 4'hF);
        bus_i.waddr  = 18'h20028;
        bus_i.wdata  = 32'h1;
        bus_i.wen    = 4'hF;
        bus_i.raddr0 = 18'h20024;
        cyc();
        bus_i.wen = 4'd0;
        cyc();
        cyc();
        check("t6_restart", bus_i.rdata0, 32'd10);
        cyc();
        check("t6_restart_dec", bus_i.rdata0, 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
